// File: rtl/button_press_emulator_pkg.sv
// ============================================================================
// Module  : button_press_emulator_pkg
// Purpose : Shared constants for the button press emulator: state encodings,
//           default press/gap timing and a small integer max helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package button_press_emulator_pkg;

  // State encodings
  localparam logic [1:0] EMU_IDLE  = 2'd0;
  localparam logic [1:0] EMU_PRESS = 2'd1;
  localparam logic [1:0] EMU_GAP   = 2'd2;

  // Default timing
  localparam int EMU_PRESS_CYCLES_DEF = 4;
  localparam int EMU_GAP_CYCLES_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = EMU_IDLE,
    ST_PRESS = EMU_PRESS,
    ST_GAP   = EMU_GAP
  } emu_state_e;

  function automatic int emu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_press_emulator_press_timer.sv
// ============================================================================
// Module  : press_timer
// Purpose : Loadable down-counter with a zero flag. Counts down by one per
//           cycle until it reaches zero, then holds. A load overrides the
//           count.
// Ports   : Clk        - clock, rising edge
//           Rst        - asynchronous active-high reset (count -> 0)
//           load_i     - load load_val_i this cycle
//           load_val_i - value to load
//           zero_o     - count is zero
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module press_timer #(
  parameter int MAX_CYCLES = 4,
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/button_press_emulator.sv
// ============================================================================
// Module  : button_press_emulator
// Purpose : Turns single-cycle request pulses into active-low button presses
//           of PRESS_CYCLES low cycles, each followed by GAP_CYCLES high
//           cycles. Requests arriving while busy are queued in a saturating
//           counter of depth QUEUE_DEPTH.
// Ports   : Clk        - clock, rising edge
//           Rst        - asynchronous active-high reset
//           Pulse_In   - press request (one per high cycle)
//           Button_Out - emulated button, active-low, idles high
//           Busy       - high in PRESS and GAP
//           Pending    - queued requests not yet started
//           Ovf_Clr    - clears Overflow   (BUTTON_EMU_OVERFLOW_EN only)
//           Overflow   - sticky drop flag  (BUTTON_EMU_OVERFLOW_EN only)
// Config  : define BUTTON_EMU_OVERFLOW_EN to add the overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_press_emulator
  import button_press_emulator_pkg::*;
#(
  parameter int PRESS_CYCLES = EMU_PRESS_CYCLES_DEF,
  parameter int GAP_CYCLES   = EMU_GAP_CYCLES_DEF,
  parameter int QUEUE_DEPTH  = 3,
  localparam int PW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Pulse_In,
  output logic          Button_Out,
  output logic          Busy,
  output logic [PW-1:0] Pending
`ifdef BUTTON_EMU_OVERFLOW_EN
  ,
  input  logic          Ovf_Clr,
  output logic          Overflow
`endif
);

  localparam int TMAX = emu_max(PRESS_CYCLES, GAP_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  emu_state_e    state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          button_q, busy_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          start;     // a new press begins next cycle
  logic          q_full;

  press_timer #(
    .MAX_CYCLES (TMAX)
  ) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign q_full = (pending_q == PW'(QUEUE_DEPTH));

  // Next state and timer loads
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Pulse_In || (pending_q != '0)) begin
          state_d  = ST_PRESS;
          tmr_load = 1'b1;
          tmr_val  = TW'(PRESS_CYCLES - 1);
          start    = 1'b1;
        end
      end
      ST_PRESS: begin
        if (tmr_zero) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (Pulse_In || (pending_q != '0)) begin
            state_d  = ST_PRESS;
            tmr_load = 1'b1;
            tmr_val  = TW'(PRESS_CYCLES - 1);
            start    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue accounting. When a press starts, a same-cycle pulse either starts
  // directly (empty queue) or replaces the dequeued entry, so Pending only
  // drops when the start is served purely from the queue.
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      if (!Pulse_In) begin
        pending_d = pending_q - PW'(1);
      end
    end else if (Pulse_In && !q_full) begin
      pending_d = pending_q + PW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      button_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // Outputs registered from the next state so they align with state_q
      button_q  <= (state_d != ST_PRESS);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign Button_Out = button_q;
  assign Busy       = busy_q;
  assign Pending    = pending_q;

`ifdef BUTTON_EMU_OVERFLOW_EN
  logic drop;
  logic ovf_q, ovf_d;

  assign drop = Pulse_In && !start && q_full;

  // Set has priority over clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Ovf_Clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

`default_nettype wire
